// File: rtl/bus_uart_fifo.sv
// Bus-attached 8N1 UART with TX/RX FIFOs, runtime baud divisor, sticky error flags,
// per-source interrupt enables and optional CTS/RTS flow control.
module bus_uart_fifo #(
  parameter int          DEPTH      = 16,
  parameter int          RTS_MARGIN = 4,
  parameter logic [7:0]  DIV_RESET  = 8'd12
) (
  input  logic       i_clk,
  input  logic       i_reset_b,
  input  logic       i_cs_b,
  input  logic       i_en,
  input  logic       i_rnw,
  input  logic [1:0] i_regsel,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_irq_b,
  input  logic       i_rxd,
  output logic       o_txd,
  input  logic       i_cts_b,
  output logic       o_rts_b
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] RTS_LEVEL  = (AW+1)'(DEPTH - RTS_MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic       w_access, w_wr, w_rd;
  logic       w_wrData, w_wrStat, w_wrCtrl, w_wrDiv, w_rdData, w_flush;
  logic       r_rxMeta, r_rxSync, r_rxPrev, r_ctsMeta, r_ctsSync;
  logic [2:0] r_ctrl;
  logic [7:0] r_div, r_tickCnt;
  logic       w_tick;
  logic       r_overrun, r_frameErr, r_irq, r_rts;

  logic [7:0] r_txMem [DEPTH];
  logic [7:0] r_rxMem [DEPTH];
  logic [AW:0] r_txWp, r_txRp, r_rxWp, r_rxRp, w_txCount, w_rxCount;
  logic       w_txEmpty, w_txFull, w_rxEmpty, w_rxFull;
  logic       w_txPush, w_txPop, w_rxPush, w_rxPop;

  state_t     r_txState, w_txNext, r_rxState, w_rxNext;
  logic [3:0] r_txTick, r_rxTick;
  logic [2:0] r_txBit, r_rxBit;
  logic [7:0] r_txShift, r_rxShift;
  logic       w_txCanStart, w_txBitEnd, w_txIdle, w_rxBitEnd, w_rxFall, w_rxDone;
  logic [7:0] w_status;

  assign w_access = i_en & ~i_cs_b;
  assign w_wr     = w_access & ~i_rnw;
  assign w_rd     = w_access & i_rnw;
  assign w_wrData = w_wr & (i_regsel == 2'd0);
  assign w_wrStat = w_wr & (i_regsel == 2'd1);
  assign w_wrCtrl = w_wr & (i_regsel == 2'd2);
  assign w_wrDiv  = w_wr & (i_regsel == 2'd3);
  assign w_rdData = w_rd & (i_regsel == 2'd0);
  assign w_flush  = w_wrCtrl & i_din[3];

  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_rxMeta  <= 1'b1;
      r_rxSync  <= 1'b1;
      r_rxPrev  <= 1'b1;
      r_ctsMeta <= 1'b1;
      r_ctsSync <= 1'b1;
    end else begin
      r_rxMeta  <= i_rxd;
      r_rxSync  <= r_rxMeta;
      r_rxPrev  <= r_rxSync;
      r_ctsMeta <= i_cts_b;
      r_ctsSync <= r_ctsMeta;
    end
  end

  // 16x baud tick: one pulse every r_div+1 clocks, restarted by a divisor write.
  assign w_tick = (r_tickCnt == r_div);

  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_tickCnt <= 8'd0;
      r_div     <= DIV_RESET;
      r_ctrl    <= 3'd0;
    end else begin
      if (w_wrDiv || w_tick) r_tickCnt <= 8'd0;
      else                   r_tickCnt <= r_tickCnt + 8'd1;
      if (w_wrDiv)  r_div  <= i_din;
      if (w_wrCtrl) r_ctrl <= i_din[2:0];
    end
  end

  assign w_txCount = r_txWp - r_txRp;
  assign w_rxCount = r_rxWp - r_rxRp;
  assign w_txEmpty = (w_txCount == '0);
  assign w_rxEmpty = (w_rxCount == '0);
  assign w_txFull  = (w_txCount == FULL_LEVEL);
  assign w_rxFull  = (w_rxCount == FULL_LEVEL);
  assign w_txPush  = w_wrData & ~w_txFull;
  assign w_rxPop   = w_rdData & ~w_rxEmpty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
  assign w_rxPush  = w_rxDone & (~w_rxFull | w_rxPop);

  always_ff @(posedge i_clk) begin
    if (w_txPush) r_txMem[r_txWp[AW-1:0]] <= i_din;
    if (w_rxPush) r_rxMem[r_rxWp[AW-1:0]] <= r_rxShift;
  end

  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_txWp <= '0;
      r_txRp <= '0;
      r_rxWp <= '0;
      r_rxRp <= '0;
    end else if (w_flush) begin
      r_txWp <= '0;
      r_txRp <= '0;
      r_rxWp <= '0;
      r_rxRp <= '0;
    end else begin
      if (w_txPush) r_txWp <= r_txWp + 1'b1;
      if (w_txPop)  r_txRp <= r_txRp + 1'b1;
      if (w_rxPush) r_rxWp <= r_rxWp + 1'b1;
      if (w_rxPop)  r_rxRp <= r_rxRp + 1'b1;
    end
  end

  assign w_txCanStart = ~w_txEmpty & (~r_ctrl[2] | ~r_ctsSync);
  assign w_txBitEnd   = w_tick & (r_txTick == 4'd15);
  assign w_txIdle     = w_txEmpty & (r_txState == S_IDLE);

  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) r_txState <= S_IDLE;
    else            r_txState <= w_txNext;
  end

  // A pending byte at the end of STOP goes straight into START, giving gapless frames.
  always_comb begin
    w_txNext = r_txState;
    w_txPop  = 1'b0;
    case (r_txState)
      S_IDLE:  if (w_tick && w_txCanStart) begin w_txNext = S_START; w_txPop = 1'b1; end
      S_START: if (w_txBitEnd) w_txNext = S_DATA;
      S_DATA:  if (w_txBitEnd && r_txBit == 3'd7) w_txNext = S_STOP;
      S_STOP:  if (w_txBitEnd) begin
                 if (w_txCanStart) begin w_txNext = S_START; w_txPop = 1'b1; end
                 else              w_txNext = S_IDLE;
               end
      default: w_txNext = S_IDLE;
    endcase
    if (w_flush) begin
      w_txNext = S_IDLE;
      w_txPop  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_txTick  <= 4'd0;
      r_txBit   <= 3'd0;
      r_txShift <= 8'd0;
    end else if (w_txPop) begin
      r_txTick  <= 4'd0;
      r_txBit   <= 3'd0;
      r_txShift <= r_txMem[r_txRp[AW-1:0]];
    end else if (r_txState != S_IDLE && w_tick) begin
      r_txTick <= r_txTick + 4'd1;
      if (w_txBitEnd && r_txState == S_DATA) begin
        r_txShift <= r_txShift >> 1;
        r_txBit   <= r_txBit + 3'd1;
      end
    end
  end

  always_comb begin
    o_txd = 1'b1;
    case (r_txState)
      S_START: o_txd = 1'b0;
      S_DATA:  o_txd = r_txShift[0];
      default: o_txd = 1'b1;
    endcase
  end

  assign w_rxFall   = r_rxPrev & ~r_rxSync;
  assign w_rxBitEnd = w_tick & (r_rxTick == 4'd15);

  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) r_rxState <= S_IDLE;
    else            r_rxState <= w_rxNext;
  end

  // Mid-start recheck after 8 ticks rejects glitches; later samples land mid-bit.
  always_comb begin
    w_rxNext = r_rxState;
    w_rxDone = 1'b0;
    case (r_rxState)
      S_IDLE:  if (w_rxFall) w_rxNext = S_START;
      S_START: if (w_tick && r_rxTick == 4'd7) w_rxNext = r_rxSync ? S_IDLE : S_DATA;
      S_DATA:  if (w_rxBitEnd && r_rxBit == 3'd7) w_rxNext = S_STOP;
      S_STOP:  if (w_rxBitEnd) begin w_rxNext = S_IDLE; w_rxDone = 1'b1; end
      default: w_rxNext = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_rxTick  <= 4'd0;
      r_rxBit   <= 3'd0;
      r_rxShift <= 8'd0;
    end else if (r_rxState == S_IDLE) begin
      r_rxTick <= 4'd0;
      r_rxBit  <= 3'd0;
    end else if (w_tick) begin
      if (r_rxState == S_START && r_rxTick == 4'd7) r_rxTick <= 4'd0;
      else                                          r_rxTick <= r_rxTick + 4'd1;
      if (r_rxState == S_DATA && r_rxTick == 4'd15) begin
        r_rxShift <= {r_rxSync, r_rxShift[7:1]};
        r_rxBit   <= r_rxBit + 3'd1;
      end
    end
  end

  // Error flags are sticky; a new error outranks a same-cycle write-1-to-clear.
  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
      r_irq      <= 1'b0;
      r_rts      <= 1'b0;
    end else begin
      if (w_rxDone && w_rxFull && !w_rxPop) r_overrun <= 1'b1;
      else if (w_wrStat && i_din[4])        r_overrun <= 1'b0;
      if (w_rxDone && !r_rxSync)            r_frameErr <= 1'b1;
      else if (w_wrStat && i_din[5])        r_frameErr <= 1'b0;
      r_irq <= (r_ctrl[0] & ~w_rxEmpty) | (r_ctrl[1] & w_txIdle) | r_overrun | r_frameErr;
      r_rts <= r_ctrl[2] & (w_rxCount >= RTS_LEVEL);
    end
  end

  assign o_irq_b = ~r_irq;
  assign o_rts_b = r_rts;

  assign w_status = {r_irq, ~r_ctsSync, r_frameErr, r_overrun,
                     w_txIdle, w_rxFull, ~w_txFull, ~w_rxEmpty};

  always_comb begin
    o_dout = 8'h00;
    case (i_regsel)
      2'd0: o_dout = w_rxEmpty ? 8'h00 : r_rxMem[r_rxRp[AW-1:0]];
      2'd1: o_dout = w_status;
      2'd2: o_dout = {5'd0, r_ctrl};
      2'd3: o_dout = r_div;
      default: o_dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_bus_uart_fifo.sv
// Directed self-checking bench for bus_uart_fifo: bus registers, TX waveform,
// loopback, overrun, interrupts, framing errors, glitch rejection and flow control.
module tb_bus_uart_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_b, cs_b, en, rnw, rxdDrive, loopBack, cts_b;
  logic [1:0] regsel;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq_b, txd, rts_b, rxdLine;
  int         checks = 0;
  int         failures = 0;

  assign rxdLine = loopBack ? txd : rxdDrive;

  bus_uart_fifo #(.DEPTH(DEPTH), .RTS_MARGIN(4), .DIV_RESET(8'd12)) dut (
    .i_clk(clk), .i_reset_b(reset_b), .i_cs_b(cs_b), .i_en(en), .i_rnw(rnw),
    .i_regsel(regsel), .i_din(din), .o_dout(dout), .o_irq_b(irq_b),
    .i_rxd(rxdLine), .o_txd(txd), .i_cts_b(cts_b), .o_rts_b(rts_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic busWrite(input logic [1:0] r, input logic [7:0] d);
    @(negedge clk);
    cs_b = 1'b0; en = 1'b1; rnw = 1'b0; regsel = r; din = d;
    @(posedge clk); #1;
    cs_b = 1'b1; en = 1'b0; rnw = 1'b1;
  endtask

  task automatic busRead(input logic [1:0] r, output logic [7:0] d);
    @(negedge clk);
    cs_b = 1'b0; en = 1'b1; rnw = 1'b1; regsel = r;
    #1 d = dout;
    @(posedge clk); #1;
    cs_b = 1'b1; en = 1'b0;
  endtask

  // Bit period of 16 clocks assumes DIV=0.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    @(negedge clk);
    rxdDrive = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxdDrive = b[i];
      repeat (16) @(negedge clk);
    end
    rxdDrive = stopBit;
    repeat (16) @(negedge clk);
    rxdDrive = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] rd;
    reset_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b1) begin failures++; $display("[TB] FAIL reset_txd got=%b exp=1", txd); end
    checks++; if (irq_b !== 1'b1) begin failures++; $display("[TB] FAIL reset_irq got=%b exp=1", irq_b); end
    checks++; if (rts_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_rts got=%b exp=0", rts_b); end
    @(negedge clk); reset_b = 1'b1;
    repeat (3) @(posedge clk);
    busRead(2'd1, rd);
    checks++; if (rd !== 8'h0A) begin failures++; $display("[TB] FAIL reset_status got=%h exp=0a", rd); end
    busRead(2'd3, rd);
    checks++; if (rd !== 8'h0C) begin failures++; $display("[TB] FAIL reset_div got=%h exp=0c", rd); end
    busRead(2'd2, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("[TB] FAIL reset_ctrl got=%h exp=00", rd); end
    busRead(2'd0, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("[TB] FAIL reset_rxempty got=%h exp=00", rd); end
  endtask

  task automatic test_tx_frame;
    logic [7:0] rd;
    logic [8:0] txExp;
    logic       fell;
    txExp = {1'b1, 8'h55};
    busWrite(2'd3, 8'h00);
    busWrite(2'd0, 8'h55);
    fell = 1'b0;
    for (int i = 0; i < 10 && !fell; i++) begin
      @(posedge clk); #1;
      if (txd === 1'b0) fell = 1'b1;
    end
    checks++; if (fell !== 1'b1) begin failures++; $display("[TB] FAIL tx_start got=%b exp=1", fell); end
    if (fell) begin
      repeat (15) @(posedge clk);
      #1;
      checks++; if (txd !== 1'b0) begin failures++; $display("[TB] FAIL tx_start_len got=%b exp=0", txd); end
      @(posedge clk); #1;
      checks++; if (txd !== 1'b1) begin failures++; $display("[TB] FAIL tx_start_end got=%b exp=1", txd); end
      for (int i = 0; i < 9; i++) begin
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (txd !== txExp[i]) begin
          failures++; $display("[TB] FAIL tx_bit%0d got=%b exp=%b", i, txd, txExp[i]);
        end
        repeat (8) @(posedge clk);
      end
    end
    repeat (10) @(posedge clk);
    busRead(2'd1, rd);
    checks++; if (rd !== 8'h0A) begin failures++; $display("[TB] FAIL tx_done_status got=%h exp=0a", rd); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] rd;
    logic       done;
    loopBack = 1'b1;
    busWrite(2'd3, 8'h03);
    busWrite(2'd0, 8'hA5);
    busWrite(2'd0, 8'h3C);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      repeat (10) @(posedge clk);
      busRead(2'd1, rd);
      if (rd[3] === 1'b1) done = 1'b1;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL loop_txdone got=%b exp=1", done); end
    repeat (100) @(posedge clk);
    busRead(2'd0, rd);
    checks++; if (rd !== 8'hA5) begin failures++; $display("[TB] FAIL loop_byte0 got=%h exp=a5", rd); end
    busRead(2'd0, rd);
    checks++; if (rd !== 8'h3C) begin failures++; $display("[TB] FAIL loop_byte1 got=%h exp=3c", rd); end
    busRead(2'd1, rd);
    checks++; if (rd !== 8'h0A) begin failures++; $display("[TB] FAIL loop_status got=%h exp=0a", rd); end
    loopBack = 1'b0;
  endtask

  task automatic test_overrun;
    logic [7:0] rd;
    busWrite(2'd3, 8'h00);
    for (int i = 0; i <= DEPTH; i++) sendFrame(8'(i * 13 + 1), 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (irq_b !== 1'b0) begin failures++; $display("[TB] FAIL ovr_irq got=%b exp=0", irq_b); end
    busRead(2'd1, rd);
    checks++; if (rd !== 8'h9F) begin failures++; $display("[TB] FAIL ovr_status got=%h exp=9f", rd); end
    busWrite(2'd1, 8'h10);
    repeat (3) @(posedge clk);
    busRead(2'd1, rd);
    checks++; if (rd !== 8'h0F) begin failures++; $display("[TB] FAIL ovr_clear got=%h exp=0f", rd); end
    #1;
    checks++; if (irq_b !== 1'b1) begin failures++; $display("[TB] FAIL ovr_irq_clear got=%b exp=1", irq_b); end
    for (int i = 0; i < DEPTH; i++) begin
      busRead(2'd0, rd);
      checks++;
      if (rd !== 8'(i * 13 + 1)) begin
        failures++; $display("[TB] FAIL ovr_byte%0d got=%h exp=%h", i, rd, 8'(i * 13 + 1));
      end
    end
    busRead(2'd1, rd);
    checks++; if (rd !== 8'h0A) begin failures++; $display("[TB] FAIL ovr_drained got=%h exp=0a", rd); end
  endtask

  task automatic test_irq_enables;
    logic [7:0] rd;
    busWrite(2'd2, 8'h02);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq_b !== 1'b0) begin failures++; $display("[TB] FAIL irq_tx_en got=%b exp=0", irq_b); end
    busWrite(2'd2, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq_b !== 1'b1) begin failures++; $display("[TB] FAIL irq_rx_empty got=%b exp=1", irq_b); end
    sendFrame(8'hC3, 1'b1);
    #1;
    checks++; if (irq_b !== 1'b0) begin failures++; $display("[TB] FAIL irq_rx_en got=%b exp=0", irq_b); end
    busRead(2'd0, rd);
    checks++; if (rd !== 8'hC3) begin failures++; $display("[TB] FAIL irq_rx_byte got=%h exp=c3", rd); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq_b !== 1'b1) begin failures++; $display("[TB] FAIL irq_rx_drained got=%b exp=1", irq_b); end
    busWrite(2'd2, 8'h00);
  endtask

  task automatic test_frame_err;
    logic [7:0] rd;
    sendFrame(8'h5A, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (irq_b !== 1'b0) begin failures++; $display("[TB] FAIL ferr_irq got=%b exp=0", irq_b); end
    busRead(2'd1, rd);
    checks++; if (rd !== 8'hAB) begin failures++; $display("[TB] FAIL ferr_status got=%h exp=ab", rd); end
    busRead(2'd0, rd);
    checks++; if (rd !== 8'h5A) begin failures++; $display("[TB] FAIL ferr_byte got=%h exp=5a", rd); end
    busWrite(2'd1, 8'h20);
    repeat (3) @(posedge clk);
    busRead(2'd1, rd);
    checks++; if (rd !== 8'h0A) begin failures++; $display("[TB] FAIL ferr_clear got=%h exp=0a", rd); end
    @(negedge clk); rxdDrive = 1'b0;
    repeat (4) @(negedge clk);
    rxdDrive = 1'b1;
    repeat (200) @(posedge clk);
    busRead(2'd1, rd);
    checks++; if (rd !== 8'h0A) begin failures++; $display("[TB] FAIL glitch_status got=%h exp=0a", rd); end
  endtask

  task automatic test_flow;
    logic [7:0] rd;
    logic       sawLow;
    int         lat;
    busWrite(2'd2, 8'h04);
    busWrite(2'd0, 8'h81);
    sawLow = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (txd === 1'b0) sawLow = 1'b1;
    end
    checks++; if (sawLow !== 1'b0) begin failures++; $display("[TB] FAIL flow_hold got=%b exp=0", sawLow); end
    @(negedge clk); cts_b = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (txd === 1'b0) lat = i;
    end
    checks++;
    if (lat < 2 || lat > 4) begin failures++; $display("[TB] FAIL flow_start_latency got=%0d exp=2..4", lat); end
    repeat (170) @(posedge clk);
    busRead(2'd1, rd);
    checks++; if (rd !== 8'h4A) begin failures++; $display("[TB] FAIL flow_txdone got=%h exp=4a", rd); end
    for (int i = 0; i < DEPTH - 5; i++) sendFrame(8'(i), 1'b1);
    #1;
    checks++; if (rts_b !== 1'b0) begin failures++; $display("[TB] FAIL rts_below got=%b exp=0", rts_b); end
    sendFrame(8'hEE, 1'b1);
    #1;
    checks++; if (rts_b !== 1'b1) begin failures++; $display("[TB] FAIL rts_level got=%b exp=1", rts_b); end
    busWrite(2'd2, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rts_b !== 1'b0) begin failures++; $display("[TB] FAIL rts_flowoff got=%b exp=0", rts_b); end
    busWrite(2'd2, 8'h08);
    repeat (3) @(posedge clk);
    busRead(2'd1, rd);
    checks++; if (rd !== 8'h4A) begin failures++; $display("[TB] FAIL flush_status got=%h exp=4a", rd); end
    busRead(2'd2, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("[TB] FAIL flush_ctrl got=%h exp=00", rd); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] rd;
    busWrite(2'd0, 8'h00);
    repeat (40) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b0) begin failures++; $display("[TB] FAIL midframe_busy got=%b exp=0", txd); end
    @(negedge clk); reset_b = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin failures++; $display("[TB] FAIL midframe_async_txd got=%b exp=1", txd); end
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    repeat (4) @(posedge clk);
    busRead(2'd1, rd);
    checks++; if (rd !== 8'h4A) begin failures++; $display("[TB] FAIL midframe_status got=%h exp=4a", rd); end
    busRead(2'd3, rd);
    checks++; if (rd !== 8'h0C) begin failures++; $display("[TB] FAIL midframe_div got=%h exp=0c", rd); end
  endtask

  initial begin
    reset_b = 1'b0; cs_b = 1'b1; en = 1'b0; rnw = 1'b1; regsel = 2'd0; din = 8'h00;
    rxdDrive = 1'b1; loopBack = 1'b0; cts_b = 1'b1;
    test_reset;
    test_tx_frame;
    test_back_to_back;
    test_overrun;
    test_irq_enables;
    test_frame_err;
    test_flow;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_uart_fifo.md
Name: bus_uart_fifo

Overview:
Bus-attached 8N1 UART for the 6809 bus card, replacing the fixed single-byte UART. Adds parametrised TX/RX FIFOs, a runtime baud divisor, error flags with write-1-to-clear, per-source IRQ enables and optional CTS/RTS hardware flow control. Sits behind the card's address decode. It is clocked by the filtered bus-card clock and drives the card's open-drain interrupt line through irq_b.

Parameters:
DEPTH, 16, entries per FIFO (power of 2, 2..256)
RTS_MARGIN, 4, RTS_B deasserts when RX count >= DEPTH-RTS_MARGIN
DIV_RESET, 8'd12, baud divisor reset value (16x tick every DIV+1 clocks)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_b  input  1  reset, asynchronous, active-low
cs_b  input  1  chip select, active low
en  input  1  one-cycle access strobe; an access occurs only on a cycle with en=1 and cs_b=0
rnw  input  1  1=read, 0=write
regsel  input  2  register select
din  input  8  write data
dout  output  8  read data, combinational from regsel
irq_b  output  1  interrupt, active low
rxd  input  1  serial in, asynchronous, idle high
txd  output  1  serial out, idle high
cts_b  input  1  clear-to-send from far end, active low, asynchronous
rts_b  output  1  request-to-send to far end, active low

Behaviour:
- Reset: txd=1, rts_b=0, irq_b=1, both FIFOs empty, ctrl=0, div=DIV_RESET, error flags=0, both FSMs IDLE. dout is combinational, so it reflects reset register state.
- Registers:
  - regsel 0: read returns RX head and pops (no pop if empty, returns 0x00). Write pushes TX (dropped if full, no flag).
  - regsel 1 STATUS (read): [0] rx_avail, [1] tx_not_full, [2] rx_full, [3] tx_empty (FIFO empty and TX FSM IDLE), [4] overrun, [5] frame_err, [6] cts (=!cts_b synced), [7] irq pending. Write: 1 in bit 4/5 clears that flag.
  - regsel 2 CTRL (R/W): [0] rx_irq_en, [1] tx_irq_en, [2] flow_en, [3] fifo_flush (write-only, self-clearing; empties both FIFOs and aborts the TX frame with txd=1; reads as 0). Bits [7:4] read 0.
  - regsel 3 DIV (R/W): divisor. A write reloads the tick counter at 0.
- Access side effects occur on the single en cycle. dout is valid for the whole cycle whenever cs_b=0 and rnw=1.
- Tick generator: a 16x tick pulses one clk every DIV+1 clocks. DIV=0 gives a tick every clock.
- TX FSM: IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE, each bit lasting 16 ticks.
  - Leaves IDLE on a tick when the FIFO is non-empty and (!flow_en or cts synced low).
  - Pops the FIFO on entry to START.
  - CTS deassert mid-frame does not abort the frame.
  - Back-to-back frames have no idle gap.
- RX FSM: IDLE -> START -> DATA -> STOP, with rxd passed through a 2-flop synchroniser.
  - Falling edge in IDLE starts the FSM. The start bit is re-checked after 8 ticks; if high, it was a glitch and the FSM returns to IDLE.
  - Data bits are sampled every 16 ticks thereafter, then the stop bit.
  - If stop=0: frame_err=1 and the byte is still pushed.
  - If the FIFO is full at stop: byte dropped, overrun=1.
  - A simultaneous push and pop on a full FIFO is legal: the pop happens first, so there is no overrun.
- FIFOs: pointers one bit wider than log2(DEPTH), wrapping naturally. Simultaneous push+pop leaves the count unchanged. Push when full is ignored; pop when empty is ignored.
- rts_b = flow_en & (rx_count >= DEPTH-RTS_MARGIN); it is 0 when flow_en=0. Registered, so it updates 1 clk after the count changes.
- irq_b = !((rx_irq_en & rx_avail) | (tx_irq_en & tx_empty) | overrun | frame_err). Registered, 1 clk latency.
- Error flags: sticky until cleared by a write or by reset. If a write-1-clear and a new error occur on the same cycle, the set wins.
- reset_b assertion mid-frame: txd goes to 1 immediately (asynchronous) and all state clears.

Test Plan:
- Reset, then read STATUS -> 0x0A. Read DIV -> 0x0C; irq_b=1; txd=1.
- DIV=0, write 0x55 to reg0 -> txd low 16 clks, then bits 1,0,1,0,1,0,1,0 at 16 clks each, then stop high; total 160 clks; tx_empty=1 after.
- Loop txd->rxd, DIV=3, write 0xA5, 0x3C, then read reg0 twice -> 0xA5, then 0x3C; STATUS[0]=0 after.
- Drive DEPTH+1 frames into rxd without reading -> rx_full=1, overrun=1, irq_b=0; first DEPTH bytes intact. Write 0x10 to STATUS -> overrun=0.
- flow_en=1, cts_b=1, write 0x81 -> txd stays 1. Drop cts_b to 0 -> frame starts on the next tick. Fill RX to DEPTH-4 -> rts_b=1.
- Send a frame with stop=0 -> frame_err=1 and the byte is in the FIFO. Send a 4-tick low glitch on rxd -> no byte pushed.
